// File: rtl/ucsbece154b_sdram_responder_pkg.sv
// rtl/ucsbece154b_sdram_responder_pkg.sv - shared FSM encoding and default timing constants
// for the SDRAM burst responder.
package ucsbece154b_sdram_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2
  } state_e;

  localparam int unsigned LATENCY_DEFAULT    = 10;
  localparam int unsigned BURST_DEFAULT      = 4;
  localparam int unsigned DEPTH_LOG2_DEFAULT = 12;

endpackage

// File: rtl/ucsbece154b_sdram_array.sv
// rtl/ucsbece154b_sdram_array.sv - word-addressed backing store, one synchronous write port
// and one read port that forwards a same-cycle write so reads observe write-first ordering.
module ucsbece154b_sdram_array #(
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [31:0]           wdata_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];

endmodule

// File: rtl/ucsbece154b_sdram_responder.sv
// rtl/ucsbece154b_sdram_responder.sv - fixed-latency SDRAM model returning critical-word-first
// wrapped bursts; FSM, latency counter and burst offset generation live here.
module ucsbece154b_sdram_responder
  import ucsbece154b_sdram_responder_pkg::*;
#(
  parameter int unsigned LATENCY    = LATENCY_DEFAULT,
  parameter int unsigned BURST      = BURST_DEFAULT,
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ReadRequest_i,
  input  logic [31:0]              SDRAM_ReadAddress_i,
  input  logic                     WriteRequest_i,
  input  logic [31:0]              WriteAddress_i,
  input  logic [31:0]              WriteData_i,
  output logic                     Ready_o,
  output logic [31:0]              SDRAM_DataIn_o,
  output logic                     DataValid_o,
  output logic [$clog2(BURST)-1:0] WordOffset_o,
  output logic                     BurstLast_o
);

  localparam int unsigned OFFW = $clog2(BURST);
  localparam int unsigned BLKW = DEPTH_LOG2 - OFFW;

  state_e                state_q, state_d;
  logic [5:0]            cnt_q, cnt_d;
  logic [BLKW-1:0]       blk_q, blk_d, blk_cur;
  logic [OFFW-1:0]       off_q, off_d, off_cur;
  logic [OFFW-1:0]       beat_q, beat_d, beat_cur;
  logic                  ready_q, ready_d, valid_q, valid_d, last_q, last_d;
  logic [31:0]           data_q, data_d, rdata;
  logic [OFFW-1:0]       woff_q, woff_d;
  logic [DEPTH_LOG2-1:0] rd_idx_in, wr_idx, rd_idx;
  logic                  emit, wr_en;
  logic                  unused_addr_bits;

  assign rd_idx_in = SDRAM_ReadAddress_i[DEPTH_LOG2+1:2];
  assign wr_idx    = WriteAddress_i[DEPTH_LOG2+1:2];
  assign unused_addr_bits = ^{SDRAM_ReadAddress_i[31:DEPTH_LOG2+2], SDRAM_ReadAddress_i[1:0],
                              WriteAddress_i[31:DEPTH_LOG2+2], WriteAddress_i[1:0]};

  // In IDLE the word to emit comes straight from the request so LATENCY=1 needs no extra cycle.
  assign blk_cur  = (state_q == ST_IDLE) ? rd_idx_in[DEPTH_LOG2-1:OFFW] : blk_q;
  assign off_cur  = (state_q == ST_IDLE) ? rd_idx_in[OFFW-1:0] : off_q;
  assign beat_cur = (state_q == ST_BURST) ? beat_q : '0;
  assign rd_idx   = {blk_cur, off_cur};
  assign wr_en    = WriteRequest_i && (state_q == ST_IDLE) && !reset;

  ucsbece154b_sdram_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_idx),
    .wdata_i (WriteData_i),
    .raddr_i (rd_idx),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      blk_q   <= '0;
      off_q   <= '0;
      beat_q  <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      woff_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      off_q   <= off_d;
      beat_q  <= beat_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
      woff_q  <= woff_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    off_d   = off_q;
    beat_d  = beat_q;
    unique case (state_q)
      ST_IDLE: if (ReadRequest_i) begin
        blk_d = blk_cur;
        off_d = off_cur;
        if (LATENCY == 1) begin
          state_d = ST_BURST;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = 6'(LATENCY - 1);
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) state_d = ST_BURST;
      end
      ST_BURST: if (last_q) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // Outputs are registered, so a word is launched on the edge that enters or stays in BURST.
    emit = (state_d == ST_BURST);
    if (emit) begin
      off_d  = off_cur + OFFW'(1);
      beat_d = beat_cur + OFFW'(1);
    end
  end

  always_comb begin
    ready_d = (state_d == ST_IDLE);
    valid_d = emit;
    last_d  = emit && (beat_cur == OFFW'(BURST - 1));
    data_d  = emit ? rdata : '0;
    woff_d  = emit ? off_cur : '0;
  end

  assign Ready_o        = ready_q;
  assign DataValid_o    = valid_q;
  assign BurstLast_o    = last_q;
  assign SDRAM_DataIn_o = data_q;
  assign WordOffset_o   = woff_q;

endmodule
